// File: rtl/ysyx_22040931_dmem_resp.sv
// rtl/ysyx_22040931_dmem_resp.sv - MEM-stage data-memory responder with latency model
// Optional build macro: YSYX_22040931_DMEM_MISALIGN_CHK_EN (flags misaligned H/W/D accesses as errors)
module ysyx_22040931_dmem_resp #(
    parameter int                ADDR_W    = 64,
    parameter int                DEPTH     = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(64'h8000_0000),
    parameter int                LATENCY   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_ena,
    input  logic              mem_wr,
    input  logic [1:0]        memop,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [63:0]       mem_stor_data,
    output logic              mem_ready,
    output logic              mem_resp_valid,
    output logic [63:0]       mem_data,
    output logic              mem_err
);

    localparam int                IDX_W  = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] SPAN   = ADDR_W'(8 * DEPTH);
    localparam logic [3:0]        LAT_M2 = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;
    localparam bit                LAT1   = (LATENCY == 1);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t            state;
    logic [3:0]        cnt;
    logic              q_wr;
    logic [1:0]        q_op;
    logic [ADDR_W-1:0] q_addr;
    logic [63:0]       q_data;

    logic [63:0]       ram [DEPTH];

    logic              accept;
    logic              commit;
    logic              c_wr;
    logic [1:0]        c_op;
    logic [ADDR_W-1:0] c_addr;
    logic [63:0]       c_data;
    logic [ADDR_W-1:0] off;
    logic [IDX_W-1:0]  idx;
    logic              in_range;
    logic              misalign;
    logic              ok;
    logic [7:0]        size_mask;
    logic [7:0]        strb;
    logic [63:0]       lane_mask;
    logic [63:0]       load_val;

    // Ready depends on state only; a request in WAIT is simply not taken
    assign mem_ready = (state != WAIT);
    assign accept    = mem_ena & mem_ready;

    // With single-cycle latency the accept edge commits the live request;
    // otherwise the commit happens at the end of WAIT from the latched copy
    assign commit = LAT1 ? accept : ((state == WAIT) && (cnt == 4'd0));
    assign c_wr   = LAT1 ? mem_wr        : q_wr;
    assign c_op   = LAT1 ? memop         : q_op;
    assign c_addr = LAT1 ? mem_addr      : q_addr;
    assign c_data = LAT1 ? mem_stor_data : q_data;

    // Address decode, size masks, byte strobes and right-justified load data
    always_comb begin
        off      = c_addr - BASE_ADDR;
        idx      = off[IDX_W+2:3];
        in_range = (c_addr >= BASE_ADDR) && (off < SPAN);
        misalign = 1'b0;
`ifdef YSYX_22040931_DMEM_MISALIGN_CHK_EN
        case (c_op)
            2'b01:   misalign = c_addr[0];
            2'b10:   misalign = (c_addr[1:0] != 2'b00);
            2'b11:   misalign = (c_addr[2:0] != 3'b000);
            default: misalign = 1'b0;
        endcase
`endif
        ok = in_range & ~misalign;
        case (c_op)
            2'b00:   begin size_mask = 8'h01; lane_mask = 64'h0000_0000_0000_00FF; end
            2'b01:   begin size_mask = 8'h03; lane_mask = 64'h0000_0000_0000_FFFF; end
            2'b10:   begin size_mask = 8'h0F; lane_mask = 64'h0000_0000_FFFF_FFFF; end
            default: begin size_mask = 8'hFF; lane_mask = 64'hFFFF_FFFF_FFFF_FFFF; end
        endcase
        // Lanes pushed past byte 7 fall off the top: only the addressed doubleword is touched
        strb     = size_mask << c_addr[2:0];
        load_val = (ram[idx] >> {c_addr[2:0], 3'b000}) & lane_mask;
    end

    // Request FSM with latency counter and registered response outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            mem_resp_valid <= 1'b0;
            mem_data       <= 64'd0;
            mem_err        <= 1'b0;
            q_wr           <= 1'b0;
            q_op           <= 2'b00;
            q_addr         <= '0;
            q_data         <= 64'd0;
        end else begin
            mem_resp_valid <= 1'b0;
            if (commit) begin
                mem_resp_valid <= 1'b1;
                mem_err        <= ~ok;
                mem_data       <= (ok && !c_wr) ? load_val : 64'd0;
            end
            if (accept) begin
                q_wr   <= mem_wr;
                q_op   <= memop;
                q_addr <= mem_addr;
                q_data <= mem_stor_data;
            end
            case (state)
                IDLE, RESP: begin
                    if (accept) begin
                        if (LAT1) begin
                            state <= RESP;
                        end else begin
                            state <= WAIT;
                            cnt   <= LAT_M2;
                        end
                    end else begin
                        state <= IDLE;
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Byte-strobed RAM write at commit; contents survive reset
    always_ff @(posedge clk) begin
        if (!rst && commit && c_wr && ok) begin
            for (int b = 0; b < 8; b++) begin
                if (strb[b]) begin
                    ram[idx][8*b +: 8] <= c_data[8*b +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ysyx_22040931_dmem_resp.sv
// tb/tb_ysyx_22040931_dmem_resp.sv - directed self-checking bench for the data-memory responder
module tb_ysyx_22040931_dmem_resp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        rst4;

    logic        u1_ena, u1_wr, u1_ready, u1_valid, u1_err;
    logic [1:0]  u1_op;
    logic [63:0] u1_addr, u1_sdata, u1_data;

    logic        u3_ena, u3_wr, u3_ready, u3_valid, u3_err;
    logic [1:0]  u3_op;
    logic [63:0] u3_addr, u3_sdata, u3_data;

    logic        u4_ena, u4_wr, u4_ready, u4_valid, u4_err;
    logic [1:0]  u4_op;
    logic [63:0] u4_addr, u4_sdata, u4_data;

    int total = 0;
    int bad   = 0;

    ysyx_22040931_dmem_resp #(.LATENCY(1)) u1 (
        .clk(clk), .rst(rst), .mem_ena(u1_ena), .mem_wr(u1_wr), .memop(u1_op),
        .mem_addr(u1_addr), .mem_stor_data(u1_sdata), .mem_ready(u1_ready),
        .mem_resp_valid(u1_valid), .mem_data(u1_data), .mem_err(u1_err)
    );

    ysyx_22040931_dmem_resp #(.LATENCY(3)) u3 (
        .clk(clk), .rst(rst), .mem_ena(u3_ena), .mem_wr(u3_wr), .memop(u3_op),
        .mem_addr(u3_addr), .mem_stor_data(u3_sdata), .mem_ready(u3_ready),
        .mem_resp_valid(u3_valid), .mem_data(u3_data), .mem_err(u3_err)
    );

    ysyx_22040931_dmem_resp #(.LATENCY(4)) u4 (
        .clk(clk), .rst(rst4), .mem_ena(u4_ena), .mem_wr(u4_wr), .memop(u4_op),
        .mem_addr(u4_addr), .mem_stor_data(u4_sdata), .mem_ready(u4_ready),
        .mem_resp_valid(u4_valid), .mem_data(u4_data), .mem_err(u4_err)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One LATENCY=1 transaction; call at a negedge with the responder ready
    task automatic t1(input logic wr, input logic [1:0] op, input logic [63:0] addr,
                      input logic [63:0] sdata, output logic [63:0] rd, output logic er);
        u1_ena = 1'b1; u1_wr = wr; u1_op = op; u1_addr = addr; u1_sdata = sdata;
        @(negedge clk);
        u1_ena = 1'b0;
        chk("u1_resp_valid", {63'd0, u1_valid}, 64'd1);
        rd = u1_data;
        er = u1_err;
    endtask

    // One LATENCY=4 transaction with a bounded wait for the response
    task automatic t4(input logic wr, input logic [1:0] op, input logic [63:0] addr,
                      input logic [63:0] sdata, output logic [63:0] rd);
        int n;
        u4_ena = 1'b1; u4_wr = wr; u4_op = op; u4_addr = addr; u4_sdata = sdata;
        @(negedge clk);
        u4_ena = 1'b0;
        n = 1;
        while (!u4_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("u4_latency", 64'(n), 64'd4);
        rd = u4_data;
    endtask

    logic [63:0] rd;
    logic        er;
    int          vcnt;

    initial begin
        rst = 1'b1; rst4 = 1'b1;
        u1_ena = 0; u1_wr = 0; u1_op = 0; u1_addr = 0; u1_sdata = 0;
        u3_ena = 0; u3_wr = 0; u3_op = 0; u3_addr = 0; u3_sdata = 0;
        u4_ena = 0; u4_wr = 0; u4_op = 0; u4_addr = 0; u4_sdata = 0;
        repeat (2) @(negedge clk);
        rst = 1'b0; rst4 = 1'b0;

        chk("rst_valid", {63'd0, u1_valid}, 64'd0);
        chk("rst_data",  u1_data, 64'd0);
        chk("rst_err",   {63'd0, u1_err}, 64'd0);
        chk("rst_ready", {63'd0, u1_ready}, 64'd1);
        chk("rst_ready4", {63'd0, u4_ready}, 64'd1);

        // Doubleword store/load round trip
        t1(1'b1, 2'b11, 64'h8000_0000, 64'h1122_3344_5566_7788, rd, er);
        chk("st_d_err", {63'd0, er}, 64'd0);
        chk("resp_ready", {63'd0, u1_ready}, 64'd1);
        t1(1'b0, 2'b11, 64'h8000_0000, 64'd0, rd, er);
        chk("ld_d_data", rd, 64'h1122_3344_5566_7788);
        chk("ld_d_err", {63'd0, er}, 64'd0);

        // Byte store into lane 2, word load
        t1(1'b1, 2'b00, 64'h8000_0002, 64'h0000_0000_00AB_0000, rd, er);
        t1(1'b0, 2'b10, 64'h8000_0000, 64'd0, rd, er);
        chk("ld_w_data", rd, 64'h0000_0000_55AB_7788);

        // Out-of-range below and above
        t1(1'b0, 2'b01, 64'h7FFF_FFFE, 64'd0, rd, er);
        chk("oor_lo_err", {63'd0, er}, 64'd1);
        chk("oor_lo_data", rd, 64'd0);
        t1(1'b1, 2'b01, 64'h8000_2000, 64'hFFFF_FFFF_FFFF_FFFF, rd, er);
        chk("oor_hi_err", {63'd0, er}, 64'd1);
        t1(1'b0, 2'b11, 64'h8000_0000, 64'd0, rd, er);
        chk("oor_ram_kept", rd, 64'h1122_3344_55AB_7788);

        // Sub-word loads from upper lanes
        t1(1'b0, 2'b00, 64'h8000_0007, 64'd0, rd, er);
        chk("ld_b7", rd, 64'h11);
        t1(1'b0, 2'b01, 64'h8000_0006, 64'd0, rd, er);
        chk("ld_h6", rd, 64'h1122);
        t1(1'b0, 2'b10, 64'h8000_0004, 64'd0, rd, er);
        chk("ld_w4", rd, 64'h1122_3344);

        // Last doubleword of the RAM
        t1(1'b1, 2'b11, 64'h8000_1FF8, 64'hCAFE_F00D_1234_5678, rd, er);
        chk("last_st_err", {63'd0, er}, 64'd0);
        t1(1'b0, 2'b11, 64'h8000_1FF8, 64'd0, rd, er);
        chk("last_ld", rd, 64'hCAFE_F00D_1234_5678);

        // Misaligned accesses
        t1(1'b0, 2'b01, 64'h8000_0001, 64'd0, rd, er);
`ifdef YSYX_22040931_DMEM_MISALIGN_CHK_EN
        chk("mis_h_err", {63'd0, er}, 64'd1);
        chk("mis_h_data", rd, 64'd0);
`else
        chk("mis_h_err", {63'd0, er}, 64'd0);
        chk("mis_h_data", rd, 64'hAB77);
`endif
        t1(1'b1, 2'b10, 64'h8000_0006, 64'hDEAD_0000_0000_0000, rd, er);
`ifdef YSYX_22040931_DMEM_MISALIGN_CHK_EN
        chk("mis_w_err", {63'd0, er}, 64'd1);
`else
        chk("mis_w_err", {63'd0, er}, 64'd0);
`endif
        t1(1'b0, 2'b11, 64'h8000_0000, 64'd0, rd, er);
`ifdef YSYX_22040931_DMEM_MISALIGN_CHK_EN
        chk("mis_w_ram", rd, 64'h1122_3344_55AB_7788);
`else
        chk("mis_w_ram", rd, 64'hDEAD_3344_55AB_7788);
`endif

        // Single pulse, outputs hold while idle
        @(negedge clk);
        chk("pulse_end", {63'd0, u1_valid}, 64'd0);
        chk("hold_data", u1_data, rd);

        // LATENCY=3: WAIT-cycle requests are ignored
        u3_ena = 1'b1; u3_wr = 1'b1; u3_op = 2'b11; u3_addr = 64'h8000_0010;
        u3_sdata = 64'hA5A5_A5A5_5A5A_5A5A;
        @(negedge clk);
        chk("u3_w1_ready", {63'd0, u3_ready}, 64'd0);
        chk("u3_w1_valid", {63'd0, u3_valid}, 64'd0);
        u3_ena = 1'b0;
        @(negedge clk);
        chk("u3_w2_ready", {63'd0, u3_ready}, 64'd0);
        chk("u3_w2_valid", {63'd0, u3_valid}, 64'd0);
        u3_ena = 1'b1; u3_sdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        u3_ena = 1'b0;
        chk("u3_resp_valid", {63'd0, u3_valid}, 64'd1);
        chk("u3_resp_ready", {63'd0, u3_ready}, 64'd1);
        @(negedge clk);
        chk("u3_pulse_end", {63'd0, u3_valid}, 64'd0);
        u3_ena = 1'b1; u3_wr = 1'b0;
        @(negedge clk);
        u3_ena = 1'b0;
        vcnt = 1;
        while (!u3_valid && vcnt < 10) begin
            @(negedge clk);
            vcnt++;
        end
        chk("u3_latency", 64'(vcnt), 64'd3);
        chk("u3_ld_data", u3_data, 64'hA5A5_A5A5_5A5A_5A5A);

        // LATENCY=4: reset during WAIT drops the pending store
        t4(1'b1, 2'b11, 64'h8000_0020, 64'h0123_4567_89AB_CDEF, rd);
        @(negedge clk);
        u4_ena = 1'b1; u4_wr = 1'b1; u4_op = 2'b11; u4_addr = 64'h8000_0020;
        u4_sdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        u4_ena = 1'b0;
        chk("u4_wait_ready", {63'd0, u4_ready}, 64'd0);
        rst4 = 1'b1;
        @(negedge clk);
        rst4 = 1'b0;
        chk("u4_rst_ready", {63'd0, u4_ready}, 64'd1);
        vcnt = 0;
        for (int i = 0; i < 6; i++) begin
            if (u4_valid) vcnt++;
            @(negedge clk);
        end
        chk("u4_no_resp", 64'(vcnt), 64'd0);
        t4(1'b0, 2'b11, 64'h8000_0020, 64'd0, rd);
        chk("u4_ram_kept", rd, 64'h0123_4567_89AB_CDEF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
